wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback arbiter: merges alu and mem result streams onto one register write port,
// with a one-entry alu hold buffer, mem starvation guard and a pending-load scoreboard.
// Optional operand-forwarding outputs are enabled with macro WB_STAGE_FWD_EN.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [4:0]      iss_rd,
  output logic [31:0]     busy,
  output logic            rd_w,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_in
`ifdef WB_STAGE_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  logic            hold_vld;
  logic [4:0]      hold_rd;
  logic [XLEN-1:0] hold_data;
  logic [1:0]      starv_cnt;

  logic            mem_xfer, alu_xfer, iss_xfer;
  logic            sel_mem, sel_hold, sel_alu, sel_vld;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            hold_load;
  logic [31:0]     busy_set, busy_clr, busy_nxt;

  // Starvation guard: after two mem wins over an occupied hold, mem yields one cycle.
  assign mem_ready = (starv_cnt != 2'd2);
  assign mem_xfer  = mem_valid & mem_ready;
  assign sel_mem   = mem_xfer;
  assign sel_hold  = hold_vld & ~mem_xfer;
  assign alu_ready = ~hold_vld | sel_hold;
  assign alu_xfer  = alu_valid & alu_ready;
  assign sel_alu   = alu_xfer & ~hold_vld & ~mem_xfer;
  assign sel_vld   = sel_mem | sel_hold | sel_alu;

  // An accepted alu result that does not win this cycle waits in hold, preserving order.
  assign hold_load = alu_xfer & ~sel_alu;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    if (sel_mem) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end else if (sel_hold) begin
      sel_rd   = hold_rd;
      sel_data = hold_data;
    end else if (sel_alu) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  assign iss_ready = ~((iss_rd != 5'd0) & busy[iss_rd]);
  assign iss_xfer  = iss_valid & iss_ready;

  // Set wins over clear on the same index; r0 never tracked.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (iss_xfer && iss_rd != 5'd0) busy_set[iss_rd] = 1'b1;
    if (mem_xfer)                   busy_clr[mem_rd] = 1'b1;
    busy_nxt    = (busy & ~busy_clr) | busy_set;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_rd   <= '0;
      hold_data <= '0;
      starv_cnt <= '0;
      busy      <= '0;
      rd_w      <= 1'b0;
      rd        <= '0;
      rd_in     <= '0;
    end else begin
      busy  <= busy_nxt;
      rd_w  <= sel_vld & (sel_rd != 5'd0);
      rd    <= sel_rd;
      rd_in <= sel_data;

      if (hold_load) begin
        hold_vld  <= 1'b1;
        hold_rd   <= alu_rd;
        hold_data <= alu_data;
      end else if (sel_hold) begin
        hold_vld  <= 1'b0;
      end

      if (sel_hold)
        starv_cnt <= '0;
      else if (hold_vld && mem_xfer)
        starv_cnt <= starv_cnt + 2'd1;
    end
  end

`ifdef WB_STAGE_FWD_EN
  assign fwd_valid = sel_vld & (sel_rd != 5'd0);
  assign fwd_rd    = sel_rd;
  assign fwd_data  = sel_data;
`endif

endmodule
